// File: rtl/calc2_pkg.sv
// Shared command/response encodings, capture FSM states and the default queue entry
// layout for the calc2 request channels.
package calc2_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic {
    CAP_IDLE,
    CAP_WAIT_OP2
  } cap_state_e;

  // Default-width entry; the core passes an entry type sized to its own parameters.
  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  tag;
    logic        invalid;
  } q_entry_t;

  function automatic logic is_valid_cmd(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

endpackage

// File: rtl/calc2_port_q.sv
// One request channel: two-cycle command/operand capture FSM feeding a circular
// request FIFO whose head is offered to the shared arbiter.
module calc2_port_q
  import calc2_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 2,
  parameter type entry_t = q_entry_t
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] data,
  input  logic [TAG_W-1:0]  tag,
  input  logic              ready,
  input  logic              pop,
  output logic              empty,
  output logic              full,
  output entry_t            head
);

  localparam int unsigned AW = $clog2(DEPTH);

  cap_state_e        state_q, state_d;
  logic [3:0]        cmd_q;
  logic [DATA_W-1:0] op1_q;
  logic [TAG_W-1:0]  tag_q;
  logic              latch;
  logic              push;
  entry_t            push_entry;

  logic [AW:0]       wptr, rptr;
  entry_t            mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    latch      = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    case (state_q)
      CAP_IDLE: begin
        if (ready && cmd != CMD_NOP) begin
          if (is_valid_cmd(cmd)) begin
            latch   = 1'b1;
            state_d = CAP_WAIT_OP2;
          end else begin
            push               = 1'b1;
            push_entry.cmd     = cmd;
            push_entry.op1     = data;
            push_entry.tag     = tag;
            push_entry.invalid = 1'b1;
          end
        end
      end
      CAP_WAIT_OP2: begin
        // The FIFO slot was reserved when the command was accepted in IDLE.
        push           = 1'b1;
        push_entry.cmd = cmd_q;
        push_entry.op1 = op1_q;
        push_entry.op2 = data;
        push_entry.tag = tag_q;
        state_d        = CAP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CAP_IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        cmd_q <= cmd;
        op1_q <= data;
        tag_q <= tag;
      end
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop && !empty) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/calc2_core.sv
// Multi-channel calculator: per-channel request queues, round-robin issue into one
// registered ALU, and a tagged one-cycle response on the originating channel.
module calc2_core
  import calc2_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TAG_W     = 2
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*4-1:0]      req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
  input  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [NUM_PORTS*2-1:0]      out_resp,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [NUM_PORTS*TAG_W-1:0]  out_tag
);

  localparam int unsigned PW = $clog2(NUM_PORTS);
  localparam int unsigned SW = $clog2(DATA_W);

  typedef struct packed {
    logic [3:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [TAG_W-1:0]  tag;
    logic              invalid;
  } entry_t;

  logic [NUM_PORTS-1:0] q_empty, q_full, q_pop;
  entry_t               q_head [NUM_PORTS];
  logic                 rdy_en;

  logic [PW-1:0]        ptr, gnt_idx;
  logic                 gnt;
  int unsigned          idx;

  logic                 iss_valid;
  logic [PW-1:0]        iss_port;
  entry_t               iss_entry;

  logic [DATA_W:0]      sum;
  logic [1:0]           alu_resp;
  logic [DATA_W-1:0]    alu_data;

  logic                 res_valid;
  logic [PW-1:0]        res_port;
  logic [1:0]           res_resp;
  logic [DATA_W-1:0]    res_data;
  logic [TAG_W-1:0]     res_tag;

  // rdy_en holds req_ready low until the first edge after reset release.
  assign req_ready = {NUM_PORTS{rdy_en}} & ~q_full;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    calc2_port_q #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .entry_t(entry_t)
    ) u_port_q (
      .clk  (c_clk),
      .rst_n(reset),
      .cmd  (req_cmd_in[4*g +: 4]),
      .data (req_data_in[DATA_W*g +: DATA_W]),
      .tag  (req_tag_in[TAG_W*g +: TAG_W]),
      .ready(req_ready[g]),
      .pop  (q_pop[g]),
      .empty(q_empty[g]),
      .full (q_full[g]),
      .head (q_head[g])
    );
  end

  always_comb begin
    gnt     = 1'b0;
    gnt_idx = ptr;
    idx     = 0;
    q_pop   = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = (32'(ptr) + i) % NUM_PORTS;
      if (!gnt && !q_empty[idx]) begin
        gnt     = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    if (gnt) q_pop[gnt_idx] = 1'b1;
  end

  always_comb begin
    alu_resp = RESP_ERR;
    alu_data = '0;
    sum      = {1'b0, iss_entry.op1} + {1'b0, iss_entry.op2};
    if (!iss_entry.invalid) begin
      case (iss_entry.cmd)
        CMD_ADD: if (!sum[DATA_W]) begin
          alu_resp = RESP_OK;
          alu_data = sum[DATA_W-1:0];
        end
        CMD_SUB: if (iss_entry.op2 <= iss_entry.op1) begin
          alu_resp = RESP_OK;
          alu_data = iss_entry.op1 - iss_entry.op2;
        end
        CMD_SHL: begin
          alu_resp = RESP_OK;
          alu_data = iss_entry.op1 << iss_entry.op2[SW-1:0];
        end
        CMD_SHR: begin
          alu_resp = RESP_OK;
          alu_data = iss_entry.op1 >> iss_entry.op2[SW-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rdy_en    <= 1'b0;
      ptr       <= PW'(NUM_PORTS - 1);
      iss_valid <= 1'b0;
      iss_port  <= '0;
      iss_entry <= '0;
      res_valid <= 1'b0;
      res_port  <= '0;
      res_resp  <= RESP_NONE;
      res_data  <= '0;
      res_tag   <= '0;
    end else begin
      rdy_en    <= 1'b1;
      if (gnt) ptr <= gnt_idx;
      iss_valid <= gnt;
      iss_port  <= gnt_idx;
      iss_entry <= q_head[gnt_idx];
      res_valid <= iss_valid;
      res_port  <= iss_port;
      res_resp  <= alu_resp;
      res_data  <= alu_data;
      res_tag   <= iss_entry.tag;
    end
  end

  always_comb begin
    out_resp = {NUM_PORTS{RESP_NONE}};
    out_data = '0;
    out_tag  = '0;
    if (res_valid) begin
      out_resp[32'(res_port)*2 +: 2]           = res_resp;
      out_data[32'(res_port)*DATA_W +: DATA_W] = res_data;
      out_tag[32'(res_port)*TAG_W +: TAG_W]    = res_tag;
    end
  end

endmodule

// File: doc/calc2_core.md
Name: calc2_core

Overview:
Parametrised successor to calc1: NUM_PORTS request channels share one ALU (add, sub, shift left, shift right). Each request carries a tag, and each channel has its own request queue. Each channel's capture FSM collects the two-cycle command/operand protocol and pushes complete requests into that channel's FIFO. A round-robin arbiter issues one request per cycle to the ALU and returns a tagged response on the originating channel.

Parameters:
NUM_PORTS, 4, number of request/response channels (2..8)
DATA_W, 32, operand/result width
DEPTH, 4, entries per channel FIFO (power of 2, >=2)
TAG_W, 2, request tag width, echoed on response

Ports:
c_clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-low reset (0 = reset)
req_cmd_in  in  NUM_PORTS*4  per-channel command; channel i at bits [4i+:4]
req_data_in  in  NUM_PORTS*DATA_W  per-channel operand
req_tag_in  in  NUM_PORTS*TAG_W  per-channel tag, sampled with the command
req_ready  out  NUM_PORTS  channel may start a new request this cycle
out_resp  out  NUM_PORTS*2  per-channel response code
out_data  out  NUM_PORTS*DATA_W  per-channel result
out_tag  out  NUM_PORTS*TAG_W  per-channel echoed tag

Behaviour:
- Reset asserted (async, any time):
  - all outputs 0; req_ready 0 while reset is low, 1 from the first edge after release.
  - FIFOs empty, FSMs IDLE, arbiter pointer = NUM_PORTS-1 so channel 0 is granted first.
  - in-flight requests are discarded; no stale response appears after release.
- Commands: 0 nop, 1 add, 2 sub, 5 shl, 6 shr; all others are invalid.
- Response codes: 0 none, 1 success, 2 overflow/underflow/invalid; 3 is never driven.
- Capture FSM per channel, states IDLE and WAIT_OP2:
  - IDLE, cmd!=0, req_ready=1, valid cmd: latch cmd, op1=data, tag; go to WAIT_OP2.
  - IDLE, invalid cmd: push an invalid entry in the same edge; stay IDLE. No op2 cycle.
  - IDLE, cmd!=0 while req_ready=0: ignored, no response ever.
  - WAIT_OP2: next cycle's data is op2, whatever cmd is; push entry; go to IDLE.
- req_ready = FIFO not full. It is only meaningful in IDLE; the slot is guaranteed through WAIT_OP2 because only this FSM pushes.
- Arbiter:
  - each cycle, grant the first non-empty FIFO searching from pointer+1 (wrap) and pop it.
  - on grant, pointer = granted index; no grant leaves the pointer unchanged.
  - push and pop on the same FIFO in the same edge are both honoured.
- ALU, result registered (one register stage), DATA_W arithmetic:
  - add: carry out -> resp 2, data 0; else resp 1, data = op1+op2.
  - sub: op2>op1 -> resp 2, data 0; else resp 1, data = op1-op2.
  - shl/shr: amount = op2[$clog2(DATA_W)-1:0], zero fill, always resp 1.
  - invalid entry: resp 2, data 0.
- Response timing:
  - the granted channel's out_resp/out_data/out_tag are valid for exactly one cycle; other channels drive 0.
  - uncontended latency: op2 sampled at edge T, response visible after edge T+2.
  - invalid command sampled at edge T: response visible after edge T+2.
- Ordering: responses per channel stay in request order; no ordering across channels.
- No starvation: a non-empty channel is granted within NUM_PORTS cycles.

Decomposition:
- calc2_pkg:
  - command localparams CMD_NOP/ADD/SUB/SHL/SHR.
  - response localparams RESP_NONE/OK/ERR.
  - queue entry struct {cmd, op1, op2, tag, invalid}.
- Sub-module calc2_port_q, instantiated NUM_PORTS times:
  - capture FSM plus circular FIFO (read/write pointers with extra wrap bit).
  - exports empty, full, head entry, pop.
- Top level holds the round-robin arbiter, the ALU, and the output demux.

Test Plan:
1. Ch0 add, op1=0x0000_0001, op2=0x01FF_FFFF, tag 2 -> out_resp[ch0]=1, out_data=0x0200_0000, out_tag=2, exactly 2 edges after op2, one cycle wide.
2. Ch0 add 0xFFFF_FFFF + 1 -> resp 2, data 0. Sub 0x1 - 0xF -> resp 2, data 0. Cmd 3 and cmd 4 (single cycle each) -> resp 2, data 0; the next cycle's cmd 1 is accepted as a new request.
3. Ch1 shl 0x1 by 31 -> 0x8000_0000, resp 1. Shr 0x8000_0000 by 31 -> 0x1. Shl by op2=32 -> amount 0, data unchanged, resp 1.
4. All four channels issue add in the same cycle (tags 0..3) -> responses on ch0, ch1, ch2, ch3 in four consecutive cycles. Then ch3 and ch1 together -> ch1 first, then ch3.
5. All channels stream 12 back-to-back requests with random operands -> req_ready deasserts at least once per channel. Every accepted request gets exactly one correct, in-order response; ignored requests get none.
6. Reset pulled low while FIFOs are half full and ch2 is in WAIT_OP2 -> all outputs 0 immediately. No responses after release; first new add completes normally.
